space_monsters_wave: RTL and testbench
======================================

SPACE_MONSTERS_WAVE -- requirements
Module: space_monsters_wave

Interface
REQ-001 The block SHALL provide parameters (name, default, meaning), one per line:
- GRID_X0, 40: grid left edge at level load (px)
- GRID_Y0, 48: grid top edge at level load (px)
- X_MIN, 8: leftmost allowed grid_x (px)
- X_MAX, 600: rightmost allowed grid right edge (px)
- STEP_X, 2: horizontal march step (px)
- STEP_Y, 16: descend step (px)
- Y_LIMIT, 400: invasion line (px)
REQ-002 The block SHALL provide ports (name, direction, width, meaning), one per line:
- clk, in, 1: system clock; one clock domain only
- rst, in, 1: synchronous active-high reset
- level_in, in, 3: 0 = idle, 1 = level 1, 2 or more = level 2
- tick, in, 1: one-cycle frame pulse
- hit_valid, in, 1: bullet-collision request
- hit_row, in, 2: collided monster row, 0 = top
- hit_col, in, 3: collided monster column, 0 = left
- alive_mask, out, 32: bit row*8+col = 1 means the monster is alive
- grid_x, out, 10: grid left edge (px)
- grid_y, out, 10: grid top edge (px)
- hit_ack, out, 1: one-cycle pulse when a live monster is killed
- win, out, 1: one-cycle pulse when the wave is cleared
- tank_destroyed, out, 1: level signal; the grid has reached Y_LIMIT
- busy, out, 1: high in LOAD, MARCH and DESCEND

Function
REQ-003 Grid geometry SHALL be 4 rows x 8 columns, 32 px column pitch and 24 px row pitch; grid width 256 px, height 96 px.
REQ-004 The FSM SHALL have the states IDLE, LOAD, MARCH, DESCEND, CLEARED and INVADED.
REQ-005 The block SHALL register level_in every cycle; a change to a nonzero value different from the registered level SHALL enter LOAD from any state.
REQ-006 If level_in = 0, the block SHALL go to IDLE with alive_mask = 0 and tank_destroyed = 0.
REQ-007 LOAD SHALL last exactly one cycle: alive_mask = all ones, grid_x = GRID_X0, grid_y = GRID_Y0, direction = right, divider = 0; the next state SHALL be MARCH.
REQ-008 The march interval SHALL be 8 ticks for level 1 and 4 ticks for level 2; the divider SHALL count ticks only in MARCH.
REQ-009 A move SHALL occur when the divider reaches interval-1 on a tick; the divider SHALL then clear.
REQ-010 Moving right: if grid_x+256+STEP_X > X_MAX, go to DESCEND; otherwise grid_x += STEP_X.
REQ-011 Moving left: if grid_x < X_MIN+STEP_X, go to DESCEND; otherwise grid_x -= STEP_X.
REQ-012 DESCEND SHALL last one cycle: grid_y += STEP_Y and direction inverts. If the new grid_y+96 >= Y_LIMIT, go to INVADED; otherwise return to MARCH.
REQ-013 INVADED SHALL hold tank_destroyed = 1 and freeze the grid until LOAD, IDLE or reset.
REQ-014 A hit_valid in LOAD, MARCH or DESCEND with the addressed bit set SHALL clear that bit at the next edge and pulse hit_ack in that same cycle.
REQ-015 A hit on a dead monster, or a hit in any other state, SHALL be ignored with no hit_ack.
REQ-016 In MARCH, alive_mask = 0 SHALL move to CLEARED and pulse win for exactly one cycle. Win SHALL take priority over a same-cycle move.
REQ-017 When a hit and a tick occur in the same cycle, both SHALL take effect in that cycle.
REQ-018 CLEARED SHALL freeze the grid with alive_mask = 0 until LOAD, IDLE or reset.

Reset
REQ-019 When rst is high at a clock edge, the block SHALL enter IDLE with all outputs 0, registered level = 0, divider = 0 and direction = right.
REQ-020 Reset SHALL override level changes, hits and ticks in the same cycle; it applies even in the middle of a move.

Configuration
REQ-021 With macro SPACE_MONSTERS_WAVE_SPEEDUP_EN defined, the march interval SHALL halve (minimum 1) while the live-monster count is 8 or fewer; the count SHALL be a combinational popcount of alive_mask.
REQ-022 With SPACE_MONSTERS_WAVE_SPEEDUP_EN undefined, the march interval SHALL depend only on the level, and no popcount logic SHALL be present.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- rst, then level_in 0->1 -> LOAD for one cycle, then alive_mask = 0xFFFFFFFF, grid_x = 40, grid_y = 48, busy = 1.
- Level 1, 8 ticks -> grid_x = 42. Level 2, 4 ticks -> grid_x = 42.
- March right until grid_x = 344 -> on the next move, DESCEND, grid_y = 64, direction left.
- hit_valid, row 1, col 3 -> bit 11 clears and hit_ack pulses. The same hit repeated -> no hit_ack.
- Kill all 32 monsters, the last in the same cycle as a move tick -> one win pulse, CLEARED, grid unchanged.
- Descend repeatedly until grid_y = 304 -> tank_destroyed = 1 and held. level_in 1->2 -> LOAD, tank_destroyed = 0.

Source files
------------

// File: rtl/space_monsters_wave_if.sv
// Space-monsters wave controller bundle: level select, tick, hit request in;
// monster mask, grid position and status pulses out.
interface space_monsters_wave_if;
    logic [2:0]  level_in;
    logic        tick;
    logic        hit_valid;
    logic [1:0]  hit_row;
    logic [2:0]  hit_col;
    logic [31:0] alive_mask;
    logic [9:0]  grid_x;
    logic [9:0]  grid_y;
    logic        hit_ack;
    logic        win;
    logic        tank_destroyed;
    logic        busy;

    // Driver side (game logic / testbench)
    modport master (
        output level_in, tick, hit_valid, hit_row, hit_col,
        input  alive_mask, grid_x, grid_y, hit_ack, win, tank_destroyed, busy
    );

    // Wave controller side
    modport slave (
        input  level_in, tick, hit_valid, hit_row, hit_col,
        output alive_mask, grid_x, grid_y, hit_ack, win, tank_destroyed, busy
    );
endinterface

// File: rtl/space_monsters_wave.sv
// Space-monsters wave controller: 4x8 monster grid that marches left/right,
// descends at the play-field edges, tracks kills and reports win/invasion.
// Optional feature macro: SPACE_MONSTERS_WAVE_SPEEDUP_EN halves the march
// interval while 8 or fewer monsters remain.
module space_monsters_wave #(
    parameter int unsigned GRID_X0 = 40,
    parameter int unsigned GRID_Y0 = 48,
    parameter int unsigned X_MIN   = 8,
    parameter int unsigned X_MAX   = 600,
    parameter int unsigned STEP_X  = 2,
    parameter int unsigned STEP_Y  = 16,
    parameter int unsigned Y_LIMIT = 400
) (
    input logic                 clk,
    input logic                 rst,
    space_monsters_wave_if.slave bus
);

    localparam logic [10:0] RightSpan = 11'(256 + STEP_X);
    localparam logic [10:0] XMaxW     = 11'(X_MAX);
    localparam logic [9:0]  LeftLim   = 10'(X_MIN + STEP_X);
    localparam logic [9:0]  StepX     = 10'(STEP_X);
    localparam logic [9:0]  StepY     = 10'(STEP_Y);
    localparam logic [10:0] YLimW     = 11'(Y_LIMIT);
    localparam logic [10:0] GridH     = 11'd96;

    typedef enum logic [2:0] {
        StIdle, StLoad, StMarch, StDescend, StCleared, StInvaded
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  level_q;
    logic [31:0] mask_q, mask_d;
    logic [9:0]  gx_q, gx_d, gy_q, gy_d;
    logic        dir_q, dir_d;        // 0 = right, 1 = left
    logic [2:0]  div_q, div_d;
    logic        hit_ack_q, hit_ack_d, win_q, win_d;

    logic [4:0]  hit_idx;
    logic        hit_live;
    logic [31:0] mask_hit;
    logic [3:0]  ivl;
    logic [2:0]  ivl_m1;
    logic [9:0]  gy_step;

    assign hit_idx = {bus.hit_row, bus.hit_col};
    assign gy_step = gy_q + StepY;

`ifdef SPACE_MONSTERS_WAVE_SPEEDUP_EN
    logic [5:0] live_cnt;

    // Live-monster popcount for the late-wave speed-up
    always_comb begin
        live_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            live_cnt = live_cnt + 6'(mask_q[i]);
        end
    end

    // March interval from level, halved when few monsters remain
    always_comb begin
        ivl = (level_q >= 3'd2) ? 4'd4 : 4'd8;
        if (live_cnt <= 6'd8) begin
            ivl = ivl >> 1;
        end
        if (ivl == 4'd0) begin
            ivl = 4'd1;
        end
        ivl_m1 = 3'(ivl - 4'd1);
    end
`else
    // March interval from level only
    always_comb begin
        ivl    = (level_q >= 3'd2) ? 4'd4 : 4'd8;
        ivl_m1 = 3'(ivl - 4'd1);
    end
`endif

    // Next-state, grid motion and hit handling
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        dir_d     = dir_q;
        div_d     = div_q;
        hit_ack_d = 1'b0;
        win_d     = 1'b0;

        hit_live = bus.hit_valid && mask_q[hit_idx] &&
                   (state_q == StLoad || state_q == StMarch || state_q == StDescend);
        mask_hit = mask_q & ~(hit_live ? (32'd1 << hit_idx) : 32'd0);

        case (state_q)
            StLoad: begin
                mask_d    = mask_hit;
                hit_ack_d = hit_live;
                state_d   = StMarch;
            end
            StMarch: begin
                mask_d    = mask_hit;
                hit_ack_d = hit_live;
                // Clearing the wave wins over a move in the same cycle
                if (mask_hit == 32'd0) begin
                    state_d = StCleared;
                    win_d   = 1'b1;
                end else if (bus.tick) begin
                    if (div_q == ivl_m1) begin
                        div_d = '0;
                        if (!dir_q) begin
                            if ({1'b0, gx_q} + RightSpan > XMaxW) begin
                                state_d = StDescend;
                            end else begin
                                gx_d = gx_q + StepX;
                            end
                        end else begin
                            if (gx_q < LeftLim) begin
                                state_d = StDescend;
                            end else begin
                                gx_d = gx_q - StepX;
                            end
                        end
                    end else begin
                        div_d = div_q + 3'd1;
                    end
                end
            end
            StDescend: begin
                mask_d    = mask_hit;
                hit_ack_d = hit_live;
                gy_d      = gy_step;
                dir_d     = ~dir_q;
                state_d   = ({1'b0, gy_step} + GridH >= YLimW) ? StInvaded : StMarch;
            end
            default: ;
        endcase

        // Level select overrides everything the wave was doing
        if (bus.level_in == 3'd0) begin
            state_d   = StIdle;
            mask_d    = '0;
            hit_ack_d = 1'b0;
            win_d     = 1'b0;
        end else if (bus.level_in != level_q) begin
            state_d   = StLoad;
            mask_d    = '1;
            gx_d      = 10'(GRID_X0);
            gy_d      = 10'(GRID_Y0);
            dir_d     = 1'b0;
            div_d     = '0;
            hit_ack_d = 1'b0;
            win_d     = 1'b0;
        end
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            level_q   <= '0;
            mask_q    <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            dir_q     <= 1'b0;
            div_q     <= '0;
            hit_ack_q <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= bus.level_in;
            mask_q    <= mask_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            dir_q     <= dir_d;
            div_q     <= div_d;
            hit_ack_q <= hit_ack_d;
            win_q     <= win_d;
        end
    end

    assign bus.alive_mask     = mask_q;
    assign bus.grid_x         = gx_q;
    assign bus.grid_y         = gy_q;
    assign bus.hit_ack        = hit_ack_q;
    assign bus.win            = win_q;
    assign bus.tank_destroyed = (state_q == StInvaded);
    assign bus.busy           = (state_q == StLoad) || (state_q == StMarch) ||
                                (state_q == StDescend);

endmodule

// File: tb/tb_space_monsters_wave.sv
// Scoreboard bench for space_monsters_wave: stimulus pushes expected pulse
// events and state snapshots; one monitor process pops and compares them.
module tb_space_monsters_wave;

    typedef struct {
        string       name;
        bit          force_fail;
        bit          chk_grid;
        logic [31:0] mask;
        logic [9:0]  gx;
        logic [9:0]  gy;
        logic        busy;
        logic        td;
    } snap_t;

    typedef struct {
        string       name;
        logic        ack;
        logic        win;
        logic [31:0] mask;
        logic [9:0]  gx;
        logic [9:0]  gy;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    snap_t snap_q[$];
    ev_t   ev_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;
    bit    done   = 1'b0;

    space_monsters_wave_if bus();

    space_monsters_wave dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: compares pulses against the event queue and drains snapshots
    initial begin : monitor
        ev_t   e;
        snap_t s;
        forever begin
            @(negedge clk);
            if (bus.hit_ack === 1'b1 || bus.win === 1'b1) begin
                n_vec++;
                if (ev_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: got ack=%0b win=%0b mask=%h, required none",
                             bus.hit_ack, bus.win, bus.alive_mask);
                end else begin
                    e = ev_q.pop_front();
                    if (bus.hit_ack !== e.ack || bus.win !== e.win || bus.alive_mask !== e.mask ||
                        bus.grid_x !== e.gx || bus.grid_y !== e.gy) begin
                        n_fail++;
                        $display("FAIL %s: got ack=%0b win=%0b mask=%h gx=%0d gy=%0d, required ack=%0b win=%0b mask=%h gx=%0d gy=%0d",
                                 e.name, bus.hit_ack, bus.win, bus.alive_mask, bus.grid_x,
                                 bus.grid_y, e.ack, e.win, e.mask, e.gx, e.gy);
                    end
                end
            end
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                n_vec++;
                if (s.force_fail) begin
                    n_fail++;
                    $display("FAIL %s: wait bound expired, required condition reached", s.name);
                end else if (bus.alive_mask !== s.mask || bus.busy !== s.busy ||
                             bus.tank_destroyed !== s.td ||
                             (s.chk_grid && (bus.grid_x !== s.gx || bus.grid_y !== s.gy))) begin
                    n_fail++;
                    $display("FAIL %s: got mask=%h gx=%0d gy=%0d busy=%0b td=%0b, required mask=%h gx=%0d gy=%0d busy=%0b td=%0b",
                             s.name, bus.alive_mask, bus.grid_x, bus.grid_y, bus.busy,
                             bus.tank_destroyed, s.mask, s.gx, s.gy, s.busy, s.td);
                end
            end
            if (done) begin
                n_vec++;
                if (ev_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL missing_pulses: got %0d pending events, required 0", ev_q.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
                $finish;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input string name, input logic [31:0] mask, input logic [9:0] gx,
                        input logic [9:0] gy, input logic busy, input logic td,
                        input bit chk_grid);
        snap_t s;
        s.name = name; s.force_fail = 1'b0; s.chk_grid = chk_grid;
        s.mask = mask; s.gx = gx; s.gy = gy; s.busy = busy; s.td = td;
        snap_q.push_back(s);
    endtask

    task automatic expect_ev(input string name, input logic ack, input logic win,
                             input logic [31:0] mask, input logic [9:0] gx, input logic [9:0] gy);
        ev_t e;
        e.name = name; e.ack = ack; e.win = win; e.mask = mask; e.gx = gx; e.gy = gy;
        ev_q.push_back(e);
    endtask

    task automatic ticks(input int n);
        bus.tick = 1'b1;
        repeat (n) step();
        bus.tick = 1'b0;
    endtask

    // sel: 0 = grid_x, 1 = grid_y, 2 = tank_destroyed
    task automatic wait_for(input int sel, input int value, input int bound, input string name);
        int k = 0;
        int cur;
        snap_t s;
        while (k < bound) begin
            cur = (sel == 0) ? int'(bus.grid_x) : (sel == 1) ? int'(bus.grid_y)
                                                             : int'(bus.tank_destroyed);
            if (cur == value) break;
            step();
            k++;
        end
        if (k == bound) begin
            s.name = name; s.force_fail = 1'b1; s.chk_grid = 1'b0;
            s.mask = '0; s.gx = '0; s.gy = '0; s.busy = 1'b0; s.td = 1'b0;
            snap_q.push_back(s);
        end
    endtask

    // Stimulus
    initial begin : stim
        logic [31:0] exp_mask;
        rst = 1'b1;
        bus.level_in = 3'd0; bus.tick = 1'b0; bus.hit_valid = 1'b0;
        bus.hit_row = 2'd0; bus.hit_col = 3'd0;
        step(); step();
        snap("reset", 32'h0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        step();

        // Level 1 load and march interval of 8 ticks
        bus.level_in = 3'd1;
        step();
        snap("load_l1", 32'hFFFF_FFFF, 10'd40, 10'd48, 1'b1, 1'b0, 1'b1);
        step();
        ticks(7);
        snap("l1_7ticks", 32'hFFFF_FFFF, 10'd40, 10'd48, 1'b1, 1'b0, 1'b1);
        ticks(1);
        snap("l1_8ticks", 32'hFFFF_FFFF, 10'd42, 10'd48, 1'b1, 1'b0, 1'b1);

        // Level 2 load and march interval of 4 ticks
        bus.level_in = 3'd2;
        step();
        snap("load_l2", 32'hFFFF_FFFF, 10'd40, 10'd48, 1'b1, 1'b0, 1'b1);
        step();
        ticks(3);
        snap("l2_3ticks", 32'hFFFF_FFFF, 10'd40, 10'd48, 1'b1, 1'b0, 1'b1);
        ticks(1);
        snap("l2_4ticks", 32'hFFFF_FFFF, 10'd42, 10'd48, 1'b1, 1'b0, 1'b1);

        // Hit row 1 col 3, then the same dead monster again
        expect_ev("hit_r1c3", 1'b1, 1'b0, 32'hFFFF_F7FF, 10'd42, 10'd48);
        bus.hit_valid = 1'b1; bus.hit_row = 2'd1; bus.hit_col = 3'd3;
        step();
        step();
        bus.hit_valid = 1'b0;
        step();
        snap("after_rehit", 32'hFFFF_F7FF, 10'd42, 10'd48, 1'b1, 1'b0, 1'b1);

        // Right edge: 344 is the last position before descending
        bus.tick = 1'b1;
        wait_for(0, 344, 2000, "wait_gx_344");
        snap("at_344", 32'hFFFF_F7FF, 10'd344, 10'd48, 1'b1, 1'b0, 1'b1);
        wait_for(1, 64, 20, "wait_gy_64");
        snap("descend_1", 32'hFFFF_F7FF, 10'd344, 10'd64, 1'b1, 1'b0, 1'b1);
        repeat (4) step();
        bus.tick = 1'b0;
        snap("moved_left", 32'hFFFF_F7FF, 10'd342, 10'd64, 1'b1, 1'b0, 1'b1);

        // Kill the rest; the last kill coincides with a move tick
        exp_mask = 32'hFFFF_F7FF;
        for (int b = 0; b < 31; b++) begin
            if (b != 11) begin
                exp_mask[b] = 1'b0;
                expect_ev($sformatf("kill_%0d", b), 1'b1, 1'b0, exp_mask, 10'd342, 10'd64);
                bus.hit_valid = 1'b1; bus.hit_row = 2'(b / 8); bus.hit_col = 3'(b % 8);
                step();
            end
        end
        bus.hit_valid = 1'b0;
        ticks(3);
        expect_ev("last_kill_win", 1'b1, 1'b1, 32'h0, 10'd342, 10'd64);
        bus.tick = 1'b1; bus.hit_valid = 1'b1; bus.hit_row = 2'd3; bus.hit_col = 3'd7;
        step();
        bus.hit_valid = 1'b0;
        repeat (5) step();
        bus.tick = 1'b0;
        snap("cleared", 32'h0, 10'd342, 10'd64, 1'b0, 1'b0, 1'b1);

        // Level 1 wave left to march all the way down to the invasion line
        bus.level_in = 3'd1;
        step();
        snap("load_l1_again", 32'hFFFF_FFFF, 10'd40, 10'd48, 1'b1, 1'b0, 1'b1);
        bus.tick = 1'b1;
        wait_for(2, 1, 30000, "wait_invaded");
        snap("invaded", 32'hFFFF_FFFF, 10'd8, 10'd304, 1'b0, 1'b1, 1'b1);
        bus.hit_valid = 1'b1; bus.hit_row = 2'd0; bus.hit_col = 3'd0;
        repeat (10) step();
        bus.hit_valid = 1'b0; bus.tick = 1'b0;
        snap("invaded_held", 32'hFFFF_FFFF, 10'd8, 10'd304, 1'b0, 1'b1, 1'b1);

        bus.level_in = 3'd2;
        step();
        snap("reload_l2", 32'hFFFF_FFFF, 10'd40, 10'd48, 1'b1, 1'b0, 1'b1);

        bus.level_in = 3'd0;
        step();
        snap("idle", 32'h0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);

        // Reset beats a level change, a hit and a tick in the same cycle
        bus.level_in = 3'd1; bus.tick = 1'b1; bus.hit_valid = 1'b1; rst = 1'b1;
        step();
        snap("reset_override", 32'h0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0; bus.hit_valid = 1'b0; bus.tick = 1'b0;
        step();
        step();
        done = 1'b1;
    end

endmodule
